// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK flip-flops: accepts one command at a
// time, turns it into per-bit J/K drive (clear/set/toggle/load/count) and pulses done.

module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= (j & ~q) | (~k & q);
    end
endmodule

module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;

    state_t           state, state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] rem;
    logic             is_count;

    assign is_count  = (op_r == OP_UP) || (op_r == OP_DOWN);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= '0;
            data_r <= '0;
            rem    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                rem    <= cmd_len;
            end else if (state == EXEC && rem != '0) begin
                rem <= rem - LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    if (!is_count || rem <= LEN_W'(1) || abort) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counting uses a ripple enable: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic             run;
        logic [WIDTH-1:0] tog;
        j_out = '0;
        k_out = '0;
        run   = 1'b1;
        tog   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = run;
            run    = run & ((op_r == OP_UP) ? q[i] : ~q[i]);
        end
        if (state == EXEC) begin
            case (op_r)
                OP_CLEAR:  k_out = '1;
                OP_SET:    j_out = '1;
                OP_TOGGLE: begin j_out = '1; k_out = '1; end
                OP_LOAD:   begin j_out = data_r; k_out = ~data_r; end
                OP_UP, OP_DOWN: begin
                    if (rem != '0) begin
                        j_out = tog;
                        k_out = tog;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j_out[g]),
            .k   (k_out[g]),
            .q   (q[g])
        );
    end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: directed table, reset corner cases and random commands
// checked against a transaction-level arithmetic model of the bank.

module tb_jk_bank_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic       abort;
    logic [3:0] q, j_out, k_out;
    logic       busy, done;

    int n_pass = 0;
    int n_tot  = 0;
    logic [3:0] mq;

    jk_bank_ctrl #(.WIDTH(4), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
        .q(q), .j_out(j_out), .k_out(k_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        int         len;
        int         ab;
        logic [3:0] exp_q;
        int         exp_cyc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit is_cnt(input logic [2:0] op);
        return op == 3'd5 || op == 3'd6;
    endfunction

    // Number of EXEC cycles a command occupies.
    function automatic int ref_cyc(input logic [2:0] op, input int len, input int ab);
        if (!is_cnt(op) || len == 0) return 1;
        if (ab > 0 && ab < len) return ab;
        return len;
    endfunction

    // Bank value after a command with n counting steps applied.
    function automatic logic [3:0] ref_q(input logic [3:0] q0, input logic [2:0] op,
                                         input logic [3:0] d, input int n);
        case (op)
            3'd1: return 4'h0;
            3'd2: return 4'hF;
            3'd3: return ~q0;
            3'd4: return d;
            3'd5: return 4'((int'(q0) + n) % 16);
            3'd6: return 4'((int'(q0) - n + 16 * 64) % 16);
            default: return q0;
        endcase
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input int len,
                          input int ab, input bit noise, input logic [3:0] exp_q,
                          input int exp_cyc);
        int cnt;
        bit got;
        @(negedge clk);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = 8'(len);
        @(posedge clk); #1;
        // Spurious command while busy must be ignored.
        cmd_valid = noise; cmd_op = 3'd2; cmd_data = 4'h9; cmd_len = 8'd7;
        cnt = 0; got = 1'b0;
        while (cnt < 300 && !got) begin
            abort = (ab != 0 && cnt + 1 == ab);
            @(posedge clk); #1;
            abort = 1'b0;
            cnt++;
            if (done) begin
                got = 1'b1;
                cmd_valid = 1'b0;
            end else if (is_cnt(op) && len > 0) begin
                chk("count_step_q", int'(q), int'(ref_q(mq, op, d, cnt)));
            end
        end
        cmd_valid = 1'b0;
        chk("done_latency", got ? cnt : -1, exp_cyc);
        chk("q_after_cmd", int'(q), int'(exp_q));
        chk("busy_in_done", int'({busy, cmd_ready}), 2);
        @(posedge clk); #1;
        chk("done_drop_ready", int'({done, cmd_ready, busy}), 3'b010);
        mq = exp_q;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{3'd4, 4'hB, 0,  0, 4'hB, 1};
        tbl[1]  = '{3'd3, 4'h0, 0,  0, 4'h4, 1};
        tbl[2]  = '{3'd2, 4'h0, 0,  0, 4'hF, 1};
        tbl[3]  = '{3'd1, 4'h0, 0,  0, 4'h0, 1};
        tbl[4]  = '{3'd4, 4'hD, 0,  0, 4'hD, 1};
        tbl[5]  = '{3'd5, 4'h0, 5,  0, 4'h2, 5};
        tbl[6]  = '{3'd4, 4'h1, 0,  0, 4'h1, 1};
        tbl[7]  = '{3'd6, 4'h0, 3,  0, 4'hE, 3};
        tbl[8]  = '{3'd1, 4'h0, 0,  0, 4'h0, 1};
        tbl[9]  = '{3'd5, 4'h0, 10, 3, 4'h3, 3};
        tbl[10] = '{3'd5, 4'h0, 0,  0, 4'h3, 1};
        tbl[11] = '{3'd7, 4'h5, 0,  1, 4'h3, 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0; abort = 1'b0;
        mq = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", int'({q, cmd_ready, busy, done}), int'({4'h0, 3'b100}));
        chk("reset_jk", int'({j_out, k_out}), 0);

        do_cmd(3'd4, 4'hA, 0, 0, 1'b0, 4'hA, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("reset_from_A", int'({q, cmd_ready, busy, done}), int'({4'h0, 3'b100}));
        mq = 4'h0;

        for (int i = 0; i < 12; i++)
            do_cmd(tbl[i].op, tbl[i].data, tbl[i].len, tbl[i].ab, 1'b0,
                   tbl[i].exp_q, tbl[i].exp_cyc);

        // Reset in the middle of a count: bank cleared, no done, reset-cycle command dropped.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_len = 8'd10;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("count_before_reset", int'(q), int'(ref_q(mq, 3'd5, 4'h0, 1)));
        @(negedge clk); rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2;
        @(posedge clk); #1 rst = 1'b0; cmd_valid = 1'b0;
        chk("mid_reset_state", int'({q, cmd_ready, busy, done}), int'({4'h0, 3'b100}));
        begin
            bit saw_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (done || q != 4'h0) saw_done = 1'b1;
            end
            chk("no_done_after_reset", int'(saw_done), 0);
        end
        mq = 4'h0;

        // Abort held in IDLE must not disturb anything.
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_idle_ignored", int'({q, cmd_ready, done}), int'({4'h0, 2'b10}));

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [3:0] d;
            int len, ab, cyc, n;
            op  = 3'($urandom_range(0, 7));
            d   = 4'($urandom);
            len = $urandom_range(0, 6);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            cyc = ref_cyc(op, len, ab);
            n   = (is_cnt(op) && len > 0) ? cyc : 0;
            do_cmd(op, d, len, ab, 1'($urandom), ref_q(mq, op, d, n), cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
